// File: rtl/mem_stage.sv
// Memory access stage: one outstanding load/store on the data bus.
// Holds the pipeline while busy; aborts with a bus error on timeout.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_mem_alu_res_i,
  input  logic [31:0] ex_mem_store_data_i,
  input  logic        ex_mem_mem_rd_i,
  input  logic        ex_mem_mem_wr_i,
  input  logic [1:0]  ex_mem_size_i,
  input  logic        ex_mem_unsigned_i,
  input  logic [4:0]  ex_mem_rd_addr_i,
  input  logic        ex_mem_wb_reg_en_i,
  input  logic        ex_mem_wb_sel_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_mem_data_o,
  output logic [31:0] mem_alu_res_o,
  output logic [4:0]  mem_rd_addr_o,
  output logic        mem_wb_reg_en_o,
  output logic        mem_wb_wb_sel_o,
  output logic        mem_stall_o,
  output logic        mem_misalign_o,
  output logic        mem_bus_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [4:0]  rd_q;
  logic        wb_en_q;
  logic        wb_sel_q;
  logic        err_q;

  logic        access;
  logic        is_store;
  logic        sz_b;
  logic        sz_h;
  logic        misalign;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [15:0] lane;
  logic [7:0]  lane_b;
  logic [31:0] ld_c;
  logic        idle;
  logic        busy;
  logic        done;

  assign access   = ex_mem_mem_rd_i | ex_mem_mem_wr_i;
  assign is_store = ex_mem_mem_wr_i & ~ex_mem_mem_rd_i;
  assign sz_b     = ex_mem_size_i == 2'b00;
  assign sz_h     = ex_mem_size_i == 2'b01;
  assign misalign = (sz_h & ex_mem_alu_res_i[0])
                  | (ex_mem_size_i[1] & |ex_mem_alu_res_i[1:0]);

  assign idle = state_q == IDLE;
  assign busy = state_q == BUSY;
  assign done = state_q == DONE;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = ex_mem_store_data_i;
    unique case (1'b1)
      sz_b: begin
        be_c    = 4'b0001 << ex_mem_alu_res_i[1:0];
        wdata_c = {4{ex_mem_store_data_i[7:0]}};
      end
      sz_h: begin
        be_c    = ex_mem_alu_res_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ex_mem_store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction works off the registered address/size.
  assign lane   = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  assign lane_b = addr_q[0] ? lane[15:8] : lane[7:0];

  always_comb begin
    ld_c = dmem_rdata_i;
    unique case (1'b1)
      (size_q == 2'b00): ld_c = {{24{~uns_q & lane_b[7]}}, lane_b};
      (size_q == 2'b01): ld_c = {{16{~uns_q & lane[15]}}, lane};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      rd_q     <= '0;
      wb_en_q  <= 1'b0;
      wb_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (access && !misalign) begin
            state_q  <= BUSY;
            cnt_q    <= '0;
            addr_q   <= ex_mem_alu_res_i;
            wdata_q  <= wdata_c;
            data_q   <= '0;
            be_q     <= be_c;
            we_q     <= is_store;
            size_q   <= ex_mem_size_i;
            uns_q    <= ex_mem_unsigned_i;
            rd_q     <= ex_mem_rd_addr_i;
            wb_en_q  <= ex_mem_wb_reg_en_i;
            wb_sel_q <= ex_mem_wb_sel_i;
            err_q    <= 1'b0;
          end
        end
        BUSY: begin
          if (dmem_ack_i) begin
            state_q <= DONE;
            cnt_q   <= '0;
            data_q  <= we_q ? 32'h0 : ld_c;
          end else if (cnt_q == LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req_o   = busy;
  assign dmem_we_o    = busy & we_q;
  assign dmem_addr_o  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_be_o    = busy ? be_q : 4'h0;
  assign dmem_wdata_o = busy ? wdata_q : 32'h0;

  // Reset masks the combinational IDLE decode so nothing leaks out.
  always_comb begin
    mem_alu_res_o   = ex_mem_alu_res_i;
    mem_rd_addr_o   = ex_mem_rd_addr_i;
    mem_wb_wb_sel_o = ex_mem_wb_sel_i;
    mem_wb_reg_en_o = ex_mem_wb_reg_en_i & ~(access & misalign);
    mem_mem_data_o  = 32'h0;
    mem_stall_o     = ~rst & access & ~misalign;
    mem_misalign_o  = ~rst & access & misalign;
    mem_bus_err_o   = 1'b0;
    if (!idle) begin
      mem_alu_res_o   = addr_q;
      mem_rd_addr_o   = rd_q;
      mem_wb_wb_sel_o = wb_sel_q;
      mem_wb_reg_en_o = done & wb_en_q & ~err_q;
      mem_mem_data_o  = done ? data_q : 32'h0;
      mem_stall_o     = busy;
      mem_misalign_o  = 1'b0;
      mem_bus_err_o   = done & err_q;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic
// checked against an arithmetic model of the access rules.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ex_mem_alu_res_i = '0;
  logic [31:0] ex_mem_store_data_i = '0;
  logic        ex_mem_mem_rd_i = 1'b0;
  logic        ex_mem_mem_wr_i = 1'b0;
  logic [1:0]  ex_mem_size_i = '0;
  logic        ex_mem_unsigned_i = 1'b0;
  logic [4:0]  ex_mem_rd_addr_i = '0;
  logic        ex_mem_wb_reg_en_i = 1'b0;
  logic        ex_mem_wb_sel_i = 1'b0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic [31:0] mem_mem_data_o;
  logic [31:0] mem_alu_res_o;
  logic [4:0]  mem_rd_addr_o;
  logic        mem_wb_reg_en_o;
  logic        mem_wb_wb_sel_o;
  logic        mem_stall_o;
  logic        mem_misalign_o;
  logic        mem_bus_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_mem_alu_res_i    (ex_mem_alu_res_i),
    .ex_mem_store_data_i (ex_mem_store_data_i),
    .ex_mem_mem_rd_i     (ex_mem_mem_rd_i),
    .ex_mem_mem_wr_i     (ex_mem_mem_wr_i),
    .ex_mem_size_i       (ex_mem_size_i),
    .ex_mem_unsigned_i   (ex_mem_unsigned_i),
    .ex_mem_rd_addr_i    (ex_mem_rd_addr_i),
    .ex_mem_wb_reg_en_i  (ex_mem_wb_reg_en_i),
    .ex_mem_wb_sel_i     (ex_mem_wb_sel_i),
    .dmem_req_o          (dmem_req_o),
    .dmem_we_o           (dmem_we_o),
    .dmem_addr_o         (dmem_addr_o),
    .dmem_be_o           (dmem_be_o),
    .dmem_wdata_o        (dmem_wdata_o),
    .dmem_ack_i          (dmem_ack_i),
    .dmem_rdata_i        (dmem_rdata_i),
    .mem_mem_data_o      (mem_mem_data_o),
    .mem_alu_res_o       (mem_alu_res_o),
    .mem_rd_addr_o       (mem_rd_addr_o),
    .mem_wb_reg_en_o     (mem_wb_reg_en_o),
    .mem_wb_wb_sel_o     (mem_wb_wb_sel_o),
    .mem_stall_o         (mem_stall_o),
    .mem_misalign_o      (mem_misalign_o),
    .mem_bus_err_o       (mem_bus_err_o)
  );

  // Reference model: access rules as plain arithmetic.
  function automatic logic [3:0] m_be(input logic [1:0] sz,
                                      input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz,
                                          input logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz,
                                         input logic uns,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] w;
    logic [31:0] v;
    w = rd >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = w % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sz == 2'd1) begin
      v = w % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz,
                               input logic [31:0] a);
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  task automatic drive(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] rda, input logic en,
                       input logic sel);
    ex_mem_mem_rd_i     = rd;
    ex_mem_mem_wr_i     = wr;
    ex_mem_size_i       = sz;
    ex_mem_unsigned_i   = uns;
    ex_mem_alu_res_i    = a;
    ex_mem_store_data_i = sd;
    ex_mem_rd_addr_i    = rda;
    ex_mem_wb_reg_en_i  = en;
    ex_mem_wb_sel_i     = sel;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 1'b0);
    #2;
    n_tests++;
    if ({dmem_req_o, mem_stall_o, mem_misalign_o, mem_bus_err_o,
         dmem_we_o, dmem_be_o, dmem_addr_o} !== 41'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b stall=%b mis=%b err=%b be=%h addr=%h, want all 0",
               dmem_req_o, mem_stall_o, mem_misalign_o, mem_bus_err_o,
               dmem_be_o, dmem_addr_o);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 5'd3, 1'b1, 1'b0);
    #1;
    n_tests++;
    if ({mem_misalign_o, mem_stall_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_misalign: mis=%b stall=%b, want 0 0",
               mem_misalign_o, mem_stall_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    nop();
  endtask

  task automatic test_load_byte();
    int stall_n;
    stall_n = 0;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    if (mem_stall_o) stall_n++;
    @(posedge clk);
    #1;
    nop();
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h80FF_FFFF;
    @(negedge clk);
    if (mem_stall_o) stall_n++;
    n_tests++;
    if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o}
        !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
      n_fail++;
      $display("FAIL lb_bus: req=%b we=%b addr=%h be=%b, want 1 0 00000100 1000",
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o);
    end
    @(posedge clk);
    #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    if (mem_stall_o) stall_n++;
    n_tests++;
    if ({mem_mem_data_o, mem_wb_reg_en_o, mem_rd_addr_o,
         mem_alu_res_o, mem_wb_wb_sel_o, dmem_req_o}
        !== {32'hFFFF_FF80, 1'b1, 5'd7, 32'h103, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL lb_done: data=%h en=%b rd=%0d alu=%h sel=%b req=%b, want ffffff80 1 7 00000103 1 0",
               mem_mem_data_o, mem_wb_reg_en_o, mem_rd_addr_o,
               mem_alu_res_o, mem_wb_wb_sel_o, dmem_req_o);
    end
    n_tests++;
    if (stall_n != 2) begin
      n_fail++;
      $display("FAIL lb_stall_cycles: got %0d want 2", stall_n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_half();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD,
          5'd9, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if ({mem_stall_o, dmem_req_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL sh_idle: stall=%b req=%b, want 1 0",
               mem_stall_o, dmem_req_o);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'h1111_2222,
          5'd31, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      dmem_ack_i = (k == 4);
      @(negedge clk);
      n_tests++;
      if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
           dmem_wdata_o, mem_stall_o}
          !== {1'b1, 1'b1, 32'h200, 4'hC, 32'hABCD_ABCD, 1'b1}) begin
        n_fail++;
        $display("FAIL sh_busy_%0d: req=%b we=%b addr=%h be=%h wdata=%h stall=%b",
                 k, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
                 dmem_wdata_o, mem_stall_o);
      end
      @(posedge clk);
      #1;
    end
    dmem_ack_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_mem_data_o, mem_stall_o, mem_bus_err_o, dmem_req_o,
         mem_alu_res_o} !== {32'h0, 3'b000, 1'b0, 32'h202}) begin
      n_fail++;
      $display("FAIL sh_done: data=%h stall=%b err=%b req=%b alu=%h",
               mem_mem_data_o, mem_stall_o, mem_bus_err_o,
               dmem_req_o, mem_alu_res_o);
    end
    @(posedge clk);
    #1;
    nop();
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if ({mem_misalign_o, dmem_req_o, mem_wb_reg_en_o, mem_stall_o}
        !== 4'b1000) begin
      n_fail++;
      $display("FAIL mis_same_cycle: mis=%b req=%b en=%b stall=%b, want 1 0 0 0",
               mem_misalign_o, dmem_req_o, mem_wb_reg_en_o, mem_stall_o);
    end
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h205, 32'h55, 5'd1, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++;
    if ({mem_misalign_o, dmem_req_o, mem_stall_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL mis_half_store: mis=%b req=%b stall=%b, want 1 0 0",
               mem_misalign_o, dmem_req_o, mem_stall_o);
    end
    @(posedge clk);
    #1;
    nop();
    @(negedge clk);
    n_tests++;
    if ({mem_misalign_o, dmem_req_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_clear: mis=%b req=%b, want 0 0",
               mem_misalign_o, dmem_req_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int busy_n;
    bit done_seen;
    busy_n    = 0;
    done_seen = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd4, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    nop();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dmem_req_o) begin
        busy_n++;
      end else begin
        done_seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (busy_n != TO) begin
      n_fail++;
      $display("FAIL to_busy_cycles: got %0d want %0d", busy_n, TO);
    end
    n_tests++;
    if ({done_seen, mem_bus_err_o, mem_wb_reg_en_o, mem_mem_data_o,
         mem_stall_o} !== {1'b1, 1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL to_done: seen=%b err=%b en=%b data=%h stall=%b, want 1 1 0 0 0",
               done_seen, mem_bus_err_o, mem_wb_reg_en_o,
               mem_mem_data_o, mem_stall_o);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (mem_bus_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err_pulse: err=%b want 0", mem_bus_err_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_nop_ack_ignored();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h1234,
          5'd17, 1'b1, 1'b1);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = $urandom;
    @(negedge clk);
    n_tests++;
    if ({mem_stall_o, mem_misalign_o, dmem_req_o, mem_mem_data_o,
         mem_alu_res_o, mem_rd_addr_o, mem_wb_reg_en_o,
         mem_wb_wb_sel_o}
        !== {3'b000, 32'h0, 32'hDEAD_BEEF, 5'd17, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL nop_passthru: stall=%b mis=%b req=%b data=%h alu=%h rd=%0d en=%b sel=%b",
               mem_stall_o, mem_misalign_o, dmem_req_o, mem_mem_data_o,
               mem_alu_res_o, mem_rd_addr_o, mem_wb_reg_en_o,
               mem_wb_wb_sel_o);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if ({dmem_req_o, mem_stall_o, mem_mem_data_o} !== 34'h0) begin
      n_fail++;
      $display("FAIL ack_ignored_idle: req=%b stall=%b data=%h, want 0 0 0",
               dmem_req_o, mem_stall_o, mem_mem_data_o);
    end
    @(posedge clk);
    #1;
    dmem_ack_i = 1'b0;
    nop();
  endtask

  task automatic test_unsigned_half();
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h002, 32'h0, 5'd2, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    nop();
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h8001_1234;
    @(negedge clk);
    n_tests++;
    if ({dmem_be_o, dmem_addr_o} !== {4'hC, 32'h0}) begin
      n_fail++;
      $display("FAIL lhu_bus: be=%h addr=%h, want c 00000000",
               dmem_be_o, dmem_addr_o);
    end
    @(posedge clk);
    #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_mem_data_o !== 32'h0000_8001) begin
      n_fail++;
      $display("FAIL lhu_data: got %h want 00008001", mem_mem_data_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_busy();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd6, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    nop();
    @(negedge clk);
    n_tests++;
    if (dmem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rmb_busy: req=%b want 1", dmem_req_o);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({dmem_req_o, mem_stall_o, mem_bus_err_o, mem_misalign_o,
         dmem_be_o, dmem_addr_o, mem_mem_data_o} !== 72'h0) begin
      n_fail++;
      $display("FAIL rmb_immediate: req=%b stall=%b err=%b be=%h addr=%h data=%h",
               dmem_req_o, mem_stall_o, mem_bus_err_o, dmem_be_o,
               dmem_addr_o, mem_mem_data_o);
    end
    @(posedge clk);
    #1;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({dmem_req_o, mem_stall_o, mem_mem_data_o, mem_bus_err_o}
        !== 35'h0) begin
      n_fail++;
      $display("FAIL rmb_ack_ignored: req=%b stall=%b data=%h err=%b",
               dmem_req_o, mem_stall_o, mem_mem_data_o, mem_bus_err_o);
    end
    @(posedge clk);
    #1;
    dmem_ack_i = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 5'd8, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if ({mem_stall_o, dmem_req_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_first_stall: stall=%b req=%b, want 1 0",
               mem_stall_o, dmem_req_o);
    end
    @(posedge clk);
    #1;
    nop();
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h0000_AB00;
    @(negedge clk);
    n_tests++;
    if ({dmem_req_o, dmem_addr_o, dmem_be_o}
        !== {1'b1, 32'h300, 4'b0010}) begin
      n_fail++;
      $display("FAIL rst_first_busy: req=%b addr=%h be=%b, want 1 00000300 0010",
               dmem_req_o, dmem_addr_o, dmem_be_o);
    end
    @(posedge clk);
    #1;
    dmem_ack_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_mem_data_o !== 32'h0000_00AB) begin
      n_fail++;
      $display("FAIL rst_first_done: data=%h want 000000ab", mem_mem_data_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_back_to_back();
    logic [73:0] got;
    logic [73:0] exp;
    for (int t = 0; t < 60; t++) begin
      int unsigned op;
      int unsigned dly;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a;
      logic [31:0] sd;
      logic [31:0] rdat;
      logic [4:0]  rda;
      logic        en;
      logic        sel;
      bit          acc;
      bit          mis;
      bit          st;
      bit          tmo;
      int          nb;
      op   = $urandom_range(0, 3);
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom);
      a    = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      sd   = $urandom;
      rdat = $urandom;
      rda  = 5'($urandom);
      en   = 1'($urandom);
      sel  = 1'($urandom);
      dly  = $urandom_range(1, TO + 2);
      acc  = op != 0;
      st   = op == 2;
      mis  = acc && m_mis(sz, a);
      tmo  = dly > TO;
      nb   = tmo ? TO : int'(dly);
      drive(op[0], op[1], sz, uns, a, sd, rda, en, sel);
      @(negedge clk);
      got = {mem_stall_o, mem_misalign_o, dmem_req_o, mem_wb_reg_en_o,
             mem_alu_res_o, mem_rd_addr_o, mem_wb_wb_sel_o,
             mem_mem_data_o};
      exp = {acc && !mis, mis, 1'b0, en && !mis, a, rda, sel, 32'h0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rnd_idle_%0d: got %h want %h", t, got, exp);
      end
      @(posedge clk);
      #1;
      if (!acc || mis) continue;
      drive(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            $urandom, $urandom, 5'($urandom), 1'($urandom),
            1'($urandom));
      for (int k = 1; k <= nb; k++) begin
        dmem_ack_i   = !tmo && (k == nb);
        dmem_rdata_i = dmem_ack_i ? rdat : $urandom;
        @(negedge clk);
        n_tests++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, mem_stall_o}
            !== {1'b1, st, a & 32'hFFFF_FFFC, m_be(sz, a), 1'b1}) begin
          n_fail++;
          $display("FAIL rnd_bus_%0d_%0d: req=%b we=%b addr=%h be=%h stall=%b",
                   t, k, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
                   mem_stall_o);
        end
        if (st) begin
          n_tests++;
          if (dmem_wdata_o !== m_wdata(sz, sd)) begin
            n_fail++;
            $display("FAIL rnd_wdata_%0d_%0d: got %h want %h",
                     t, k, dmem_wdata_o, m_wdata(sz, sd));
          end
        end
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b0;
      end
      @(negedge clk);
      got = {mem_stall_o, mem_bus_err_o, dmem_req_o, mem_wb_reg_en_o,
             mem_alu_res_o, mem_rd_addr_o, mem_wb_wb_sel_o,
             mem_mem_data_o};
      exp = {1'b0, tmo, 1'b0, en && !tmo, a, rda, sel,
             (tmo || st) ? 32'h0 : m_load(sz, uns, a, rdat)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rnd_done_%0d: got %h want %h", t, got, exp);
      end
      @(posedge clk);
      #1;
    end
    nop();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_timeout();
    test_nop_ack_ignored();
    test_unsigned_half();
    test_reset_mid_busy();
    test_random_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
